// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter and the character
// producers that share the UART.
//   arb_state_t : arbiter session state (3-bit encoding)
//   ASCII_*     : common characters used by the producers
package uart_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_OWNED = 3'd2,
        S_DRAIN = 3'd3,
        S_GAP   = 3'd4
    } arb_state_t;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker (purely combinational).
// Searches upward from i_rr_ptr+1 with wrap-around and returns the first
// active request.
//   i_req      : request vector
//   i_rr_ptr   : index of the previous winner
//   o_pick     : one-hot winner (all zero when no request is active)
//   o_pick_idx : index of the winner (0 when no request is active)
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic [N_REQ-1:0] o_pick,
    output logic [IDX_W-1:0] o_pick_idx
);

    logic w_found;

    always_comb begin
        int cand;
        o_pick     = '0;
        o_pick_idx = '0;
        w_found    = 1'b0;
        cand       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            // rr_ptr < N_REQ and k <= N_REQ, so one conditional subtract
            // is a full modulo for any N_REQ.
            cand = int'(i_rr_ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!w_found && i_req[IDX_W'(cand)]) begin
                w_found                 = 1'b1;
                o_pick[IDX_W'(cand)]    = 1'b1;
                o_pick_idx              = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ character producers.
// Each producer holds req for a whole print session; sessions are granted
// one at a time, round-robin, and the owner's start/data are forwarded.
//   clk, rst       : system clock, asynchronous active-high reset
//   req            : per-requester session request (level)
//   req_start      : per-requester one-cycle start pulse
//   req_data       : per-requester character, slot i = [i*DATA_W +: DATA_W]
//   grant          : one-hot owner (registered)
//   req_busy       : owner sees uart_tx_busy, everyone else sees 1
//   uart_tx_busy   : busy from the UART TX core
//   uart_tx_start  : start pulse to the UART
//   uart_tx_data   : character to the UART (0 outside a session)
//   owner_id       : index of the owner, 0 when none
//   active         : high whenever the arbiter is not idle
//   drop_err       : sticky, a start pulse was discarded or hit a busy UART
//
// state   | meaning
// S_IDLE  | no session, waiting for any req
// S_ARB   | round-robin pick registered into grant/owner_id/rr_ptr
// S_OWNED | owner's start/data forwarded to the UART
// S_DRAIN | owner released, waiting for the UART to finish
// S_GAP   | IDLE_GAP quiet cycles before the next session
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int IDLE_GAP = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_start,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          req_busy,
    input  logic                      uart_tx_busy,
    output logic                      uart_tx_start,
    output logic [DATA_W-1:0]         uart_tx_data,
    output logic [$clog2(N_REQ)-1:0]  owner_id,
    output logic                      active,
    output logic                      drop_err
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IDLE_GAP - 1);

    arb_state_t         r_state,    w_state_nxt;
    logic [N_REQ-1:0]   r_grant,    w_grant_nxt;
    logic [ID_W-1:0]    r_owner_id, w_owner_nxt;
    logic [ID_W-1:0]    r_rr_ptr,   w_rr_nxt;
    logic [GAP_W-1:0]   r_gap_cnt,  w_gap_nxt;
    logic               r_drop_err, w_drop_nxt;

    logic [N_REQ-1:0]   w_pick;
    logic [ID_W-1:0]    w_pick_idx;
    logic               w_owned;
    logic               w_owner_req;
    logic               w_owner_start;
    logic               w_foreign_start;
    logic [N_REQ-1:0]   w_accept_mask;
    logic [DATA_W-1:0]  w_slot [N_REQ];

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (ID_W)
    ) u_rr_pick (
        .i_req      (req),
        .i_rr_ptr   (r_rr_ptr),
        .o_pick     (w_pick),
        .o_pick_idx (w_pick_idx)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_slot
        assign w_slot[g] = req_data[g*DATA_W +: DATA_W];
    end

    assign w_owned         = (r_state == S_OWNED);
    assign w_accept_mask   = w_owned ? r_grant : '0;
    assign w_owner_req     = |(req & r_grant);
    assign w_owner_start   = |(req_start & w_accept_mask);
    assign w_foreign_start = |(req_start & ~w_accept_mask);

    assign grant         = r_grant;
    assign owner_id      = r_owner_id;
    assign active        = (r_state != S_IDLE);
    assign drop_err      = r_drop_err;
    assign uart_tx_start = w_owner_start;
    assign uart_tx_data  = w_owned ? w_slot[r_owner_id] : '0;
    // grant is one-hot, so only the owner's bit follows the UART busy.
    assign req_busy      = w_owned ? (~r_grant | {N_REQ{uart_tx_busy}}) : '1;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner_id;
        w_rr_nxt    = r_rr_ptr;
        w_gap_nxt   = r_gap_cnt;
        // A busy UART still receives the owner's start; it is only flagged.
        w_drop_nxt  = r_drop_err | w_foreign_start | (w_owner_start & uart_tx_busy);
        case (r_state)
            S_IDLE: begin
                if (|req) w_state_nxt = S_ARB;
            end
            S_ARB: begin
                if (|req) begin
                    w_grant_nxt = w_pick;
                    w_owner_nxt = w_pick_idx;
                    w_rr_nxt    = w_pick_idx;
                    w_state_nxt = S_OWNED;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_OWNED: begin
                if (!w_owner_req) begin
                    w_grant_nxt = '0;
                    w_owner_nxt = '0;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!uart_tx_busy) begin
                    w_gap_nxt   = GAP_LOAD;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_owner_id <= '0;
            r_rr_ptr   <= LAST_ID;
            r_gap_cnt  <= '0;
            r_drop_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_owner_id <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_drop_err <= w_drop_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int IDLE_GAP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  req_start = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  grant;
    logic [3:0]  req_busy;
    logic        uart_tx_busy = 1'b0;
    logic        uart_tx_start;
    logic [7:0]  uart_tx_data;
    logic [1:0]  owner_id;
    logic        active;
    logic        drop_err;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who owns the UART, plus the pending phases.
    int m_owner;
    int m_last;
    int m_gap;
    bit m_arb;
    bit m_drain;
    bit m_drop;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(8), .IDLE_GAP(IDLE_GAP)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_start     (req_start),
        .req_data      (req_data),
        .grant         (grant),
        .req_busy      (req_busy),
        .uart_tx_busy  (uart_tx_busy),
        .uart_tx_start (uart_tx_start),
        .uart_tx_data  (uart_tx_data),
        .owner_id      (owner_id),
        .active        (active),
        .drop_err      (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] st;
        logic       busy;
        logic [3:0] e_grant;
        logic       e_start;
        logic [7:0] e_data;
        logic [3:0] e_rbusy;
        logic       e_active;
        logic       e_drop;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_gap   = 0;
        m_arb   = 0;
        m_drain = 0;
        m_drop  = 0;
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            if (req_start[i] && (i != m_owner || uart_tx_busy)) m_drop = 1;
        end
        if (m_owner >= 0) begin
            if (!req[m_owner[1:0]]) begin
                m_owner = -1;
                m_drain = 1;
            end
        end else if (m_drain) begin
            if (!uart_tx_busy) begin
                m_drain = 0;
                m_gap   = IDLE_GAP;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (m_arb) begin
            m_arb = 0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && req[c[1:0]]) m_owner = c;
            end
            if (m_owner >= 0) m_last = m_owner;
        end else if (req != 4'b0000) begin
            m_arb = 1;
        end
    endtask

    task automatic check_model();
        logic [3:0] e_grant;
        logic [3:0] e_rbusy;
        logic [7:0] e_data;
        logic [1:0] e_oid;
        logic       e_start;
        logic       e_active;
        e_grant = '0;
        e_rbusy = 4'b1111;
        e_data  = '0;
        e_oid   = '0;
        e_start = 1'b0;
        if (m_owner >= 0) begin
            e_grant = 4'(1 << m_owner);
            e_oid   = m_owner[1:0];
            e_start = req_start[m_owner[1:0]];
            e_data  = 8'(req_data >> (8 * m_owner));
            e_rbusy[m_owner[1:0]] = uart_tx_busy;
        end
        e_active = (m_owner >= 0) || m_arb || m_drain || (m_gap > 0);
        chk("grant",     32'(grant),         32'(e_grant));
        chk("owner_id",  32'(owner_id),      32'(e_oid));
        chk("active",    32'(active),        32'(e_active));
        chk("req_busy",  32'(req_busy),      32'(e_rbusy));
        chk("tx_start",  32'(uart_tx_start), 32'(e_start));
        chk("tx_data",   32'(uart_tx_data),  32'(e_data));
        chk("drop_err",  32'(drop_err),      32'(m_drop));
    endtask

    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        req_start = '0;
        req_data = '0;
        uart_tx_busy = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input logic [3:0] want, input int exp_edges, input string name);
        int n;
        n = 0;
        while (grant !== want && n < 40) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'(exp_edges));
    endtask

    initial begin
        tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b1111, 1'b0, 1'b0};
        tbl[1]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b1111, 1'b1, 1'b0};
        tbl[2]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h41, 4'b1110, 1'b1, 1'b0};
        tbl[3]  = '{4'b0001, 4'b0100, 1'b0, 4'b0001, 1'b0, 8'h41, 4'b1110, 1'b1, 1'b0};
        tbl[4]  = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, 8'h41, 4'b1111, 1'b1, 1'b1};
        tbl[5]  = '{4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h41, 4'b1110, 1'b1, 1'b1};
        tbl[6]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b1111, 1'b1, 1'b1};
        tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b1111, 1'b1, 1'b1};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b1111, 1'b1, 1'b1};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b1111, 1'b1, 1'b1};
        tbl[10] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b1111, 1'b0, 1'b1};

        // Table: single session, foreign start, last start on release, drain, gap.
        do_reset();
        req_data = {8'h00, 8'h43, 8'h00, 8'h41};
        for (int r = 0; r < 11; r++) begin
            req          = tbl[r].req;
            req_start    = tbl[r].st;
            uart_tx_busy = tbl[r].busy;
            sample();
            chk($sformatf("tbl%0d grant", r),  32'(grant),         32'(tbl[r].e_grant));
            chk($sformatf("tbl%0d start", r),  32'(uart_tx_start), 32'(tbl[r].e_start));
            chk($sformatf("tbl%0d data", r),   32'(uart_tx_data),  32'(tbl[r].e_data));
            chk($sformatf("tbl%0d rbusy", r),  32'(req_busy),      32'(tbl[r].e_rbusy));
            chk($sformatf("tbl%0d active", r), 32'(active),        32'(tbl[r].e_active));
            chk($sformatf("tbl%0d drop", r),   32'(drop_err),      32'(tbl[r].e_drop));
            advance();
        end

        // Two simultaneous requests; foreign start; handover after drain+gap.
        do_reset();
        req = 4'b0101;
        wait_grant(4'b0001, 2, "t2 first grant");
        req_start = 4'b0100;
        req_data  = {8'h00, 8'h43, 8'h00, 8'h41};
        sample();
        chk("t2 foreign start", 32'(uart_tx_start), 32'(0));
        chk("t2 busy view",     32'(req_busy[2]),   32'(1));
        advance();
        req_start = '0;
        sample();
        chk("t2 drop sticky", 32'(drop_err), 32'(1));
        advance();
        req = 4'b0100;
        wait_grant(4'b0100, 6, "t2 handover");

        // Long drain with a new request rising meanwhile.
        do_reset();
        req = 4'b0001;
        wait_grant(4'b0001, 2, "t4 grant");
        req_start = 4'b0001;
        uart_tx_busy = 1'b1;
        sample();
        chk("t4 start while busy", 32'(uart_tx_start), 32'(1));
        advance();
        req_start = '0;
        req = 4'b0000;
        sample();
        chk("t4 drop on busy start", 32'(drop_err), 32'(1));
        advance();
        chk("t4 grant cleared", 32'(grant), 32'(0));
        req = 4'b0010;
        for (int i = 0; i < 49; i++) tick();
        chk("t4 still draining", 32'({active, grant}), 32'({1'b1, 4'b0000}));
        uart_tx_busy = 1'b0;
        wait_grant(4'b0010, 5, "t4 after busy fall");

        // Asynchronous reset during a session.
        do_reset();
        req = 4'b1111;
        wait_grant(4'b0001, 2, "t5 grant");
        req_start = 4'b0001;
        req_data  = 32'h0000_0055;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t5 rst grant",  32'(grant),         32'(0));
        chk("t5 rst start",  32'(uart_tx_start), 32'(0));
        chk("t5 rst data",   32'(uart_tx_data),  32'(0));
        chk("t5 rst active", 32'(active),        32'(0));
        chk("t5 rst rbusy",  32'(req_busy),      32'(4'b1111));
        tick();
        req_start = '0;
        rst = 1'b0;
        wait_grant(4'b0001, 2, "t5 regrant");

        // Rotation: every owner releases for one cycle after one character.
        for (int s = 0; s < 5; s++) begin
            int n;
            chk($sformatf("t6 order %0d", s), 32'(grant), 32'(1 << (s % 4)));
            req_start = grant;
            req_data  = {4{8'h30 + 8'(s)}};
            tick();
            req_start = '0;
            req = 4'b1111 & ~grant;
            tick();
            req = 4'b1111;
            n = 0;
            while (grant == 4'b0000 && n < 40) begin
                tick();
                n++;
            end
            chk($sformatf("t6 wait %0d", s), 32'(n < 40), 32'(1));
        end
        chk("t6 no drop", 32'(drop_err), 32'(0));

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if ($urandom_range(0, 11) == 0) req[i] = 1'b0;
                end else begin
                    if ($urandom_range(0, 5) == 0) req[i] = 1'b1;
                end
            end
            req_start = 4'($urandom) & 4'($urandom) & 4'($urandom);
            req_data  = $urandom;
            if ($urandom_range(0, 4) == 0) uart_tx_busy = ~uart_tx_busy;
            if (c == 2000) begin
                do_reset();
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
